// File: rtl/lc3_mem_arbiter.sv
// Shares the LC-3 main-memory port between fetch, data and debug requesters,
// one transaction at a time, hiding the memory's fixed read latency.
module lc3_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic              d_req,
  input  logic              x_req,
  input  logic              f_we,
  input  logic              d_we,
  input  logic              x_we,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W-1:0] x_wdata,
  output logic              f_gnt,
  output logic              d_gnt,
  output logic              x_gnt,
  output logic              f_rvalid,
  output logic              d_rvalid,
  output logic              x_rvalid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OWN_F, OWN_D, OWN_X, OWN_NONE} owner_t;

  state_t            state;
  owner_t            owner;
  owner_t            win;
  logic              lat_we;
  logic [CNT_W-1:0]  cnt;
  logic              rr_last_d;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // Fetch never writes; the port exists only for symmetry with the others.
  logic unused_f_we;
  assign unused_f_we = f_we;

  // Debug always wins; d/f ties go to whichever was not granted last.
  function automatic owner_t pick_owner(input logic x, input logic d,
                                        input logic f, input logic last_d);
    if (x)          return OWN_X;
    else if (d && f) return last_d ? OWN_F : OWN_D;
    else if (d)     return OWN_D;
    else if (f)     return OWN_F;
    else            return OWN_NONE;
  endfunction

  always_comb begin
    win       = pick_owner(x_req, d_req, f_req, rr_last_d);
    win_we    = 1'b0;
    win_addr  = f_addr;
    win_wdata = '0;
    case (win)
      OWN_X: begin
        win_we    = x_we;
        win_addr  = x_addr;
        win_wdata = x_wdata;
      end
      OWN_D: begin
        win_we    = d_we;
        win_addr  = d_addr;
        win_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      lat_we    <= 1'b0;
      cnt       <= '0;
      rr_last_d <= 1'b1;
      f_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      x_gnt     <= 1'b0;
      f_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      x_rvalid  <= 1'b0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_data  <= '0;
    end else begin
      f_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      x_gnt     <= 1'b0;
      f_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      x_rvalid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (state)
        IDLE, RESP: begin
          // Outputs for ISSUE are registered here so they appear with the state.
          if (win != OWN_NONE) begin
            state     <= ISSUE;
            owner     <= win;
            lat_we    <= win_we;
            busy      <= 1'b1;
            f_gnt     <= (win == OWN_F);
            d_gnt     <= (win == OWN_D);
            x_gnt     <= (win == OWN_X);
            mem_en    <= 1'b1;
            mem_we    <= win_we;
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
            if (win == OWN_D)      rr_last_d <= 1'b1;
            else if (win == OWN_F) rr_last_d <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= CNT_LOAD;
        end
        WAIT: begin
          if (cnt == '0) begin
            state    <= RESP;
            rsp_data <= lat_we ? '0 : mem_rdata;
            f_rvalid <= (owner == OWN_F);
            d_rvalid <= (owner == OWN_D);
            x_rvalid <= (owner == OWN_X);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=2.
module tb_lc3_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        f_req, d_req, x_req, f_we, d_we, x_we;
  logic [15:0] f_addr, d_addr, x_addr, d_wdata, x_wdata;
  logic        f_gnt, d_gnt, x_gnt, f_rvalid, d_rvalid, x_rvalid;
  logic        busy, mem_en, mem_we;
  logic [15:0] rsp_data, mem_addr, mem_wdata, mem_rdata;

  logic        b_f_req, b_d_req, b_x_req, b_f_we, b_d_we, b_x_we;
  logic [15:0] b_f_addr, b_d_addr, b_x_addr, b_d_wdata, b_x_wdata;
  logic        b_f_gnt, b_d_gnt, b_x_gnt, b_f_rvalid, b_d_rvalid, b_x_rvalid;
  logic        b_busy, b_mem_en, b_mem_we;
  logic [15:0] b_rsp_data, b_mem_addr, b_mem_wdata, b_mem_rdata;

  int n_chk = 0;
  int n_pass = 0;

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .d_req(d_req), .x_req(x_req),
    .f_we(f_we), .d_we(d_we), .x_we(x_we),
    .f_addr(f_addr), .d_addr(d_addr), .x_addr(x_addr),
    .d_wdata(d_wdata), .x_wdata(x_wdata),
    .f_gnt(f_gnt), .d_gnt(d_gnt), .x_gnt(x_gnt),
    .f_rvalid(f_rvalid), .d_rvalid(d_rvalid), .x_rvalid(x_rvalid),
    .rsp_data(rsp_data), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) u_dut_lat2 (
    .clk(clk), .rst_n(rst_n),
    .f_req(b_f_req), .d_req(b_d_req), .x_req(b_x_req),
    .f_we(b_f_we), .d_we(b_d_we), .x_we(b_x_we),
    .f_addr(b_f_addr), .d_addr(b_d_addr), .x_addr(b_x_addr),
    .d_wdata(b_d_wdata), .x_wdata(b_x_wdata),
    .f_gnt(b_f_gnt), .d_gnt(b_d_gnt), .x_gnt(b_x_gnt),
    .f_rvalid(b_f_rvalid), .d_rvalid(b_d_rvalid), .x_rvalid(b_x_rvalid),
    .rsp_data(b_rsp_data), .busy(b_busy), .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Memory models; reads outside an mem_en cycle return a poison value.
  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];
  logic [15:0] a_rd_p1, b_rd_p1, b_rd_p2;

  always @(posedge clk) begin
    if (!rst_n) begin
      mem_a[16'h0000] <= 16'h903F;
      mem_b[16'h0010] <= 16'hBEEF;
    end else begin
      if (mem_en && mem_we) mem_a[mem_addr] <= mem_wdata;
      if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
    end
    a_rd_p1 <= mem_en ? mem_a[mem_addr] : 16'hDEAD;
    b_rd_p1 <= b_mem_en ? mem_b[b_mem_addr] : 16'hDEAD;
    b_rd_p2 <= b_rd_p1;
  end
  assign mem_rdata   = a_rd_p1;
  assign b_mem_rdata = b_rd_p2;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick();
    n_chk++;
    if ({f_gnt, d_gnt, x_gnt, f_rvalid, d_rvalid, x_rvalid, busy, mem_en, mem_we} !== 9'b0)
      $display("FAIL reset_ctrl: got %b want 000000000",
               {f_gnt, d_gnt, x_gnt, f_rvalid, d_rvalid, x_rvalid, busy, mem_en, mem_we});
    else n_pass++;
    n_chk++;
    if ({mem_addr, mem_wdata, rsp_data} !== 48'h0)
      $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, rsp_data});
    else n_pass++;
    n_chk++;
    if ({b_busy, b_mem_en, b_rsp_data} !== 18'h0)
      $display("FAIL reset_lat2: got %h want 0", {b_busy, b_mem_en, b_rsp_data});
    else n_pass++;
    rst_n = 1'b1;
    tick();
    n_chk++;
    if ({busy, mem_en} !== 2'b00) $display("FAIL idle_after_reset: got %b want 00", {busy, mem_en});
    else n_pass++;
  endtask

  task automatic test_fetch_read();
    f_req = 1'b1; f_addr = 16'h0000;
    tick();
    n_chk++;
    if ({f_gnt, d_gnt, x_gnt, mem_en, mem_we, busy} !== 6'b100101)
      $display("FAIL fetch_issue: got %b want 100101", {f_gnt, d_gnt, x_gnt, mem_en, mem_we, busy});
    else n_pass++;
    n_chk++;
    if (mem_addr !== 16'h0000) $display("FAIL fetch_addr: got %h want 0000", mem_addr);
    else n_pass++;
    f_req = 1'b0;
    tick();
    n_chk++;
    if ({f_gnt, mem_en, f_rvalid, busy} !== 4'b0001)
      $display("FAIL fetch_wait: got %b want 0001", {f_gnt, mem_en, f_rvalid, busy});
    else n_pass++;
    tick();
    n_chk++;
    if ({f_rvalid, d_rvalid, x_rvalid, busy} !== 4'b1001)
      $display("FAIL fetch_resp: got %b want 1001", {f_rvalid, d_rvalid, x_rvalid, busy});
    else n_pass++;
    n_chk++;
    if (rsp_data !== 16'h903F) $display("FAIL fetch_data: got %h want 903f", rsp_data);
    else n_pass++;
    tick();
    n_chk++;
    if ({f_rvalid, busy} !== 2'b00) $display("FAIL fetch_done: got %b want 00", {f_rvalid, busy});
    else n_pass++;
  endtask

  task automatic test_data_write();
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h3000; d_wdata = 16'h1234;
    tick();
    n_chk++;
    if ({d_gnt, mem_en, mem_we} !== 3'b111)
      $display("FAIL write_issue: got %b want 111", {d_gnt, mem_en, mem_we});
    else n_pass++;
    n_chk++;
    if ({mem_addr, mem_wdata} !== 32'h3000_1234)
      $display("FAIL write_bus: got %h want 30001234", {mem_addr, mem_wdata});
    else n_pass++;
    d_req = 1'b0; d_we = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({d_rvalid, busy} !== 2'b11) $display("FAIL write_resp: got %b want 11", {d_rvalid, busy});
    else n_pass++;
    n_chk++;
    if (rsp_data !== 16'h0000) $display("FAIL write_rsp_data: got %h want 0000", rsp_data);
    else n_pass++;
    // Debug read raised during RESP starts straight away.
    x_req = 1'b1; x_we = 1'b0; x_addr = 16'h3000;
    tick();
    n_chk++;
    if ({x_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 16'h3000})
      $display("FAIL dbg_issue: got %h want %h", {x_gnt, mem_en, mem_we, mem_addr}, {3'b110, 16'h3000});
    else n_pass++;
    x_req = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({x_rvalid, rsp_data} !== {1'b1, 16'h1234})
      $display("FAIL dbg_readback: got %h want %h", {x_rvalid, rsp_data}, {1'b1, 16'h1234});
    else n_pass++;
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_seq [7];
    logic [2:0] g, r;
    int ng = 0;
    int multi = 0;
    exp_seq = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    f_addr = 16'h0000; d_addr = 16'h3000; d_we = 1'b0; x_addr = 16'h0000; x_we = 1'b0;
    d_req = 1'b1; f_req = 1'b1;
    for (int c = 0; c < 60 && ng < 7; c++) begin
      tick();
      g = {x_gnt, d_gnt, f_gnt};
      r = {x_rvalid, d_rvalid, f_rvalid};
      if ($countones(g) > 1 || $countones(r) > 1 || (g != 3'b0 && r != 3'b0)) multi++;
      if (g != 3'b0) begin
        n_chk++;
        if (g !== exp_seq[ng]) $display("FAIL rr_grant_%0d: got %b want %b", ng, g, exp_seq[ng]);
        else n_pass++;
        ng++;
        if (ng == 4) x_req = 1'b1;
        if (g == 3'b100) x_req = 1'b0;
        if (ng == 7) begin
          d_req = 1'b0;
          f_req = 1'b0;
        end
      end
    end
    n_chk++;
    if (ng != 7) $display("FAIL rr_timeout: got %0d grants want 7", ng);
    else n_pass++;
    n_chk++;
    if (multi != 0) $display("FAIL rr_overlap: got %0d overlapping cycles want 0", multi);
    else n_pass++;
    for (int c = 0; c < 10 && busy; c++) tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    b_f_addr = 16'h0010; b_f_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      e = {(c % 4 == 1), (c % 4 == 1), (c % 4 == 0), 1'b1};
      n_chk++;
      if ({b_f_gnt, b_mem_en, b_f_rvalid, b_busy} !== e)
        $display("FAIL b2b_cycle_%0d: got %b want %b", c, {b_f_gnt, b_mem_en, b_f_rvalid, b_busy}, e);
      else n_pass++;
      if (c % 4 == 0) begin
        n_chk++;
        if (b_rsp_data !== 16'hBEEF) $display("FAIL b2b_data_%0d: got %h want beef", c, b_rsp_data);
        else n_pass++;
      end
      if (c == 12) b_f_req = 1'b0;
    end
    tick();
    n_chk++;
    if ({b_busy, b_f_gnt, b_d_gnt, b_x_gnt, b_d_rvalid, b_x_rvalid, b_mem_we} !== 7'b0)
      $display("FAIL b2b_idle: got %b want 0",
               {b_busy, b_f_gnt, b_d_gnt, b_x_gnt, b_d_rvalid, b_x_rvalid, b_mem_we});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int viol = 0;
    f_req = 1'b1; f_addr = 16'h0000;
    tick();
    f_req = 1'b0;
    tick();
    n_chk++;
    if (busy !== 1'b1) $display("FAIL midrst_setup: got busy %b want 1", busy);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({f_gnt, d_gnt, x_gnt, f_rvalid, d_rvalid, x_rvalid, busy, mem_en, mem_we} !== 9'b0)
      $display("FAIL midrst_ctrl: got %b want 0",
               {f_gnt, d_gnt, x_gnt, f_rvalid, d_rvalid, x_rvalid, busy, mem_en, mem_we});
    else n_pass++;
    n_chk++;
    if ({rsp_data, mem_addr, mem_wdata} !== 48'h0)
      $display("FAIL midrst_data: got %h want 0", {rsp_data, mem_addr, mem_wdata});
    else n_pass++;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if ({f_gnt, d_gnt, x_gnt, f_rvalid, d_rvalid, x_rvalid, busy} != 7'b0) viol++;
    end
    n_chk++;
    if (viol != 0) $display("FAIL midrst_no_rvalid: got %0d active cycles want 0", viol);
    else n_pass++;
    d_req = 1'b1; f_req = 1'b1; d_addr = 16'h3000; d_we = 1'b0;
    tick();
    n_chk++;
    if ({x_gnt, d_gnt, f_gnt} !== 3'b001)
      $display("FAIL midrst_first_tie: got %b want 001", {x_gnt, d_gnt, f_gnt});
    else n_pass++;
    d_req = 1'b0; f_req = 1'b0;
    for (int c = 0; c < 10 && busy; c++) tick();
    tick();
  endtask

  task automatic test_withdrawn();
    int saw_d = 0;
    x_req = 1'b1; x_we = 1'b0; x_addr = 16'h3000;
    tick();
    n_chk++;
    if (x_gnt !== 1'b1) $display("FAIL wd_x_gnt: got %b want 1", x_gnt);
    else n_pass++;
    x_req = 1'b0;
    d_req = 1'b1; d_addr = 16'h0000; d_we = 1'b0;
    tick();
    if (d_gnt || d_rvalid) saw_d++;
    d_req = 1'b0;
    tick();
    if (d_gnt || d_rvalid) saw_d++;
    n_chk++;
    if ({x_rvalid, rsp_data} !== {1'b1, 16'h1234})
      $display("FAIL wd_x_resp: got %h want %h", {x_rvalid, rsp_data}, {1'b1, 16'h1234});
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (d_gnt || d_rvalid) saw_d++;
    end
    n_chk++;
    if (saw_d != 0) $display("FAIL wd_no_d: got %0d d pulses want 0", saw_d);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL wd_busy: got %b want 0", busy);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    f_req = 1'b0; d_req = 1'b0; x_req = 1'b0;
    f_we = 1'b0; d_we = 1'b0; x_we = 1'b0;
    f_addr = '0; d_addr = '0; x_addr = '0; d_wdata = '0; x_wdata = '0;
    b_f_req = 1'b0; b_d_req = 1'b0; b_x_req = 1'b0;
    b_f_we = 1'b0; b_d_we = 1'b0; b_x_we = 1'b0;
    b_f_addr = '0; b_d_addr = '0; b_x_addr = '0; b_d_wdata = '0; b_x_wdata = '0;
    test_reset();
    test_fetch_read();
    test_data_write();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_withdrawn();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/lc3_mem_arbiter.md
# lc3_mem_arbiter

Shares the single LC-3 main-memory port between three requesters: instruction fetch (from the control FSM), data load/store (from the control FSM), and an external debug/loader port. One transaction is outstanding at a time: fixed priority for debug, round-robin between data and fetch. The block sits between `control`/datapath and the memory array and hides the memory's fixed read latency behind a grant/response handshake.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `MEM_LAT`, 1, memory read latency in cycles (≥1); `mem_rdata` is valid `MEM_LAT` cycles after the `mem_en` cycle

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `{f,d,x}_req`  in  1  request: fetch, data, debug; held with fields stable until the matching `_gnt`
- `{f,d,x}_we`  in  1  1 = write, 0 = read (`f_we` is ignored and treated as 0)
- `{f,d,x}_addr`  in  ADDR_W  address
- `{d,x}_wdata`  in  DATA_W  write data
- `{f,d,x}_gnt`  out  1  one-cycle pulse: request accepted
- `{f,d,x}_rvalid`  out  1  one-cycle pulse: transaction complete
- `rsp_data`  out  DATA_W  read data; qualified by any `_rvalid`
- `busy`  out  1  transaction in flight
- `mem_en`, `mem_we`  out  1  memory strobe / write enable
- `mem_addr`  out  ADDR_W; `mem_wdata`  out  DATA_W
- `mem_rdata`  in  DATA_W

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE/RESP: arbitrate on the sampled `_req`. Winner, its `addr`/`we`/`wdata` and the owner ID are latched, and the FSM moves to ISSUE. If there is no request, the FSM goes to (or stays in) IDLE.
- Priority: `x` always wins. For `d` vs `f` both pending, the winner is the one not granted most recently between the two (`rr_last` bit; reset value = data, so fetch wins first tie). The `rr_last` bit updates only on a d or f grant.
- ISSUE (1 cycle): the owner's `_gnt` = 1, `mem_en` = 1, `mem_we`/`mem_addr`/`mem_wdata` come from the latch, and `busy` = 1. Next state is WAIT, with the counter loaded to `MEM_LAT`-1; if `MEM_LAT`=1, the counter starts at 0.
- WAIT: decrement. On the cycle the counter is 0 (the data-valid cycle), capture `mem_rdata` into `rsp_data` (reads) or 0 (writes), then go to RESP.
- RESP (1 cycle): the owner's `_rvalid` = 1 and `busy` = 1. Arbitration happens in the same cycle, so back-to-back transactions are allowed.
- Writes complete with `_rvalid` at the same latency as reads.
- `rsp_data` holds its value until the next capture.
- A requester dropping `_req` before `_gnt` is legal; it simply isn't considered.
- `_req` still high in the cycle after RESP is a new request.
- `mem_*` outputs are 0 outside ISSUE.

## Timing
- Reset (async, any state): state is IDLE. All `_gnt`, `_rvalid`, `mem_en`, `mem_we`, and `busy` are 0. `mem_addr`, `mem_wdata`, and `rsp_data` are 0. `rr_last` = data. An in-flight transaction is dropped with no `_rvalid`.
- Request sampled in IDLE at edge E0 → `_gnt`/`mem_en` during cycle E0+1. Data valid during cycle E0+1+`MEM_LAT`. `_rvalid` during cycle E0+2+`MEM_LAT`.
- Read latency from req to rvalid is `MEM_LAT`+2 cycles. Sustained throughput is one transaction per `MEM_LAT`+2 cycles.
- Exactly one `_gnt` and one `_rvalid` per transaction; never two owners' pulses in the same cycle.
- Simultaneous `x`/`d`/`f` requests: x, then the round-robin pair. Continuous `x_req` starves d/f by design.

## Test plan
- Single fetch read, `MEM_LAT`=1, `mem[0x0000`]=0x903F: `f_req`@edge0 → `f_gnt`+`mem_en` cycle 1, `f_rvalid` cycle 3, `rsp_data`=0x903F; `busy` high cycles 1–3 only.
- Data write, `d_addr`=0x3000, `d_wdata`=0x1234: `mem_we`=1, `mem_addr`=0x3000 in ISSUE, `d_rvalid` 3 cycles after req, `rsp_data`=0. A following debug read of 0x3000 returns 0x1234.
- `d_req` and `f_req` held together for 4 transactions: grants in order f,d,f,d. Adding `x_req` mid-stream grants x at the next arbitration, then d/f alternation resumes where it left off.
- Back-to-back: `f_req` held continuously, `MEM_LAT`=2: `f_gnt` pulses every 4 cycles, `f_rvalid` 4 cycles after each request, no idle cycle between RESP and ISSUE.
- Reset mid-op: assert `rst_n`=0 during WAIT. All outputs are 0 immediately (before next edge), there is no `_rvalid` after release, and the first post-reset tie of d/f grants f.
- Withdrawn request: `d_req` high then low while an `x` transaction is in flight. No `d_gnt`, no `d_rvalid`, and `busy` is 0 after x completes.
